// File: rtl/iterative_alu.sv
// Execute-stage ALU: logic and add/sub finish in one cycle, SLL/SRL shift one bit
// per cycle behind a start/busy/done handshake so control can stall on shifts.
module iterative_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [3:0]            ALUOperation,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [4:0]            shamt,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  illegal_op
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   sh_q, sh_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    srl_q, srl_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    zero_q, zero_d;
  logic                    illegal_q, illegal_d;

  // Single-cycle result for the non-shift legal codes; add/sub wrap naturally.
  function automatic logic [DATA_WIDTH-1:0] alu_fast(
    input logic [3:0]            op,
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] r;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_NOR:  r = ~(a | b);
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    sh_d      = sh_q;
    cnt_d     = cnt_q;
    srl_d     = srl_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;

    case (state_q)
      SHIFT: begin
        sh_d  = srl_q ? (sh_q >> 1) : (sh_q << 1);
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          result_d  = sh_d;
          zero_d    = (sh_d == '0);
          illegal_d = 1'b0;
          state_d   = DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request; DONE falls back to IDLE otherwise.
        state_d = IDLE;
        if (start) begin
          if (ALUOperation == OP_SLL || ALUOperation == OP_SRL) begin
            if (shamt == 5'd0) begin
              result_d  = B;
              zero_d    = (B == '0);
              illegal_d = 1'b0;
              state_d   = DONE;
            end else begin
              sh_d    = B;
              cnt_d   = shamt;
              srl_d   = (ALUOperation == OP_SRL);
              state_d = SHIFT;
            end
          end else if (ALUOperation <= OP_SUB) begin
            result_d  = alu_fast(ALUOperation, A, B);
            zero_d    = (result_d == '0);
            illegal_d = 1'b0;
            state_d   = DONE;
          end else begin
            result_d  = '0;
            zero_d    = 1'b1;
            illegal_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sh_q      <= '0;
      cnt_q     <= '0;
      srl_q     <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b1;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sh_q      <= sh_d;
      cnt_q     <= cnt_d;
      srl_q     <= srl_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy       = (state_q == SHIFT);
  assign done       = (state_q == DONE);
  assign ALUResult  = result_q;
  assign Zero       = zero_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_iterative_alu.sv
// Randomized scoreboard bench for iterative_alu: the driver queues expected
// results from an arithmetic reference model, a monitor checks every done.
module tb_iterative_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ALUOperation;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        illegal_op;

  iterative_alu #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(ALUOperation),
    .A(A), .B(B), .shamt(shamt), .busy(busy), .done(done),
    .ALUResult(ALUResult), .Zero(Zero), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_busy = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the operation table.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] sh);
    exp_t e;
    e.ill = 1'b0;
    case (op)
      4'd0: e.res = a & b;
      4'd1: e.res = a | b;
      4'd2: e.res = ~(a | b);
      4'd3: e.res = a + b;
      4'd4: e.res = a - b;
      4'd5: e.res = b << sh;
      4'd6: e.res = b >> sh;
      default: begin e.res = 32'd0; e.ill = 1'b1; end
    endcase
    e.zero = (e.res == 32'd0);
    e.cyc  = 0;
    return e;
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [4:0] sh);
    return ((op == 4'd5 || op == 4'd6) && sh != 5'd0) ? int'(sh) + 1 : 1;
  endfunction

  // Monitor: every done must match the oldest outstanding expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        if (q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("result", ALUResult, e.res);
          check("zero", {31'd0, Zero}, {31'd0, e.zero});
          check("illegal_op", {31'd0, illegal_op}, {31'd0, e.ill});
          check("done_cycle", cyc, e.cyc);
          check("busy_with_done", {31'd0, busy}, 32'd0);
        end
      end
    end
  end

  // Issue one op; long shifts are waited out, optionally with noise on the inputs.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input bit noise);
    exp_t e;
    int   lat;
    int   n;
    @(negedge clk);
    start = 1'b1; ALUOperation = op; A = a; B = b; shamt = sh;
    lat   = latency(op, sh);
    e     = model(op, a, b, sh);
    e.cyc = cyc + lat;
    q.push_back(e);
    last_busy = 0;
    if (lat > 1) begin
      n = 0;
      @(negedge clk);
      while (!done && n < 100) begin
        if (noise) begin
          start = 1'(($urandom % 2));
          ALUOperation = 4'($urandom); A = $urandom; B = $urandom; shamt = 5'($urandom);
        end else begin
          start = 1'b0;
        end
        if (busy) last_busy++;
        n++;
        @(negedge clk);
      end
      start = 1'b0;
      if (n >= 100) check("shift_timeout", 32'd1, 32'd0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_result"}, ALUResult, 32'd0);
    check({tag, "_zero"}, {31'd0, Zero}, 32'd1);
    check({tag, "_illegal"}, {31'd0, illegal_op}, 32'd0);
  endtask

  initial begin
    logic [3:0] op;
    reset = 1'b1; start = 1'b0; ALUOperation = 4'd0; A = '0; B = '0; shamt = '0;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    send(4'd3, 32'hFFFF_FFFF, 32'h0000_0001, 5'd0, 1'b0);
    idle();
    send(4'd4, 32'd5, 32'd5, 5'd0, 1'b0);
    send(4'd2, 32'd0, 32'd0, 5'd0, 1'b0);
    idle();

    send(4'd5, 32'd0, 32'h0000_1234, 5'd16, 1'b1);
    check("lui_busy_cycles", last_busy, 32'd16);
    send(4'd6, 32'd0, 32'h8000_0000, 5'd31, 1'b0);
    check("srl31_busy_cycles", last_busy, 32'd31);
    send(4'd6, 32'd0, 32'h8000_0000, 5'd0, 1'b0);
    idle();

    send(4'd9, 32'h1234_5678, 32'h9ABC_DEF0, 5'd3, 1'b0);
    send(4'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b0);
    send(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 1'b0);
    idle();

    // Abort a shift in its 4th busy cycle; the aborted op must never complete.
    @(negedge clk);
    start = 1'b1; ALUOperation = 4'd5; B = 32'h0000_00FF; shamt = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    check_reset_state("abort");
    @(negedge clk);
    reset = 1'b0;
    send(4'd1, 32'h0000_0F00, 32'h0000_00F0, 5'd0, 1'b0);
    idle();

    for (int i = 0; i < 80; i++) begin
      op = ($urandom % 4 != 0) ? 4'($urandom_range(0, 6)) : 4'($urandom);
      send(op, $urandom, ($urandom % 8 == 0) ? 32'd0 : $urandom,
           5'($urandom_range(0, 31)), 1'($urandom % 2));
      if ($urandom % 3 == 0) idle();
    end
    idle();
    repeat (5) @(negedge clk);
    check("outstanding_ops", q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/iterative_alu.md
# iterative_alu

Sequential execute-stage ALU that sits directly downstream of the ALU control decoder: it consumes the 4-bit operation code and the two register/immediate operands, and produces the result and branch zero flag. Logic and add/sub complete in one cycle; shifts (SLL, SRL, LUI-as-SLL) run iteratively one bit per cycle to keep the barrel shifter out of the datapath. A start/done handshake lets the multicycle control FSM stall on shifts.

## Interface
- DATA_WIDTH, 32, operand/result width; shift count width is 5 bits, fixed.
- clk  input  1  rising-edge clock; the block uses one clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when the block is idle or in its done cycle.
- ALUOperation  input  4  0000 AND, 0001 OR, 0010 NOR, 0011 ADD, 0100 SUB, 0101 SLL, 0110 SRL; all other codes, including 1001, are illegal.
- A  input  DATA_WIDTH  first operand (rs).
- B  input  DATA_WIDTH  second operand (rt or extended immediate); the shift source.
- shamt  input  5  shift amount; upstream drives 16 for LUI.
- busy  output  1  high while a shift is in progress.
- done  output  1  one-cycle pulse; ALUResult, Zero and illegal_op are valid in this cycle.
- ALUResult  output  DATA_WIDTH  registered result; holds until the next done.
- Zero  output  1  registered; equals (ALUResult == 0).
- illegal_op  output  1  registered; high with done when the code was illegal.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE/DONE + start:
  - Latch ALUOperation, A, B, shamt.
  - Non-shift op: compute the result at the same edge and go to DONE.
  - Shift op with shamt = 0: result = B, go to DONE.
  - Shift op with shamt > 0: load the shift register with B and the counter with shamt, go to SHIFT.
- SHIFT: each edge shifts by 1 (SLL: left, zero fill; SRL: right, zero fill) and decrements the counter. When the counter reaches 1, the final shift is written and the state goes to DONE.
- DONE: done = 1 for exactly one cycle. Without start, go to IDLE. With start, accept the new op as in IDLE (back-to-back).
- start while in SHIFT is ignored. There is no queuing, and the in-flight operation is unaffected.
- Arithmetic:
  - ADD and SUB wrap modulo 2^DATA_WIDTH; overflow is not flagged.
  - SUB = A − B, used by BEQ/BNE through Zero.
- Illegal code: ALUResult = 0, Zero = 1, illegal_op = 1, latency 1.
- Inputs changing after the capture edge do not affect the operation in flight.

## Timing
- Reset values: state IDLE, busy 0, done 0, ALUResult 0, Zero 1, illegal_op 0, counter 0.
- Reset has priority over start and aborts any in-flight shift; no done is produced for the aborted op.
- Latency is measured from the edge that captures start to the cycle in which done is high:
  - Non-shift and illegal ops: done high in the cycle after the capture edge (1 cycle).
  - Shifts: shamt + 1 cycles for shamt ≥ 1; 1 cycle for shamt = 0.
- busy:
  - Goes high in the cycle after the capture edge of a shift with shamt ≥ 1.
  - Stays high through all SHIFT cycles.
  - Is low in the done cycle.
- busy and done are never high together.
- Throughput: one non-shift op per cycle when start is held high.

## Test plan
- Reset, then ADD A=0xFFFFFFFF, B=0x00000001 -> done after 1 cycle, ALUResult=0x00000000, Zero=1, busy never high.
- SUB A=5, B=5, then with start held, NOR A=0, B=0 -> Zero=1 on the first done; next cycle done again with ALUResult=0xFFFFFFFF, Zero=0.
- SLL B=0x00001234, shamt=16 (LUI) -> busy high 16 cycles, done on cycle 17, ALUResult=0x12340000. start pulses during busy are ignored.
- SRL B=0x80000000 with shamt=31, then shamt=0 -> results 0x00000001 (32 cycles) and 0x80000000 (1 cycle).
- Code 1001 and code 0111 -> done after 1 cycle, illegal_op=1, ALUResult=0, Zero=1. A following AND clears illegal_op.
- SLL shamt=10, assert reset in the 4th SHIFT cycle -> next cycle busy=0, done=0, ALUResult=0, Zero=1. A new OR issued afterwards completes normally.
